// File: rtl/power3_result_buffer.sv
// power3_result_buffer
//   Captures results from the fixed-latency, unstallable power3 cube pipeline
//   into a small FIFO. The FIFO presents them on a valid/ready interface.
//   A credit counter throttles the upstream issuer so the FIFO can never
//   overflow.
//
// Parameters
//   LATENCY : cycles from a sample on power3.i_x to its result on
//             power3.o_xPower (>= 1)
//   DEPTH   : FIFO entries (power of two, >= 2)
//
// Ports
//   i_clk      : clock
//   i_srst     : synchronous active-high reset
//   i_xValid   : upstream drives a real sample into power3 this cycle
//   o_xReady   : a credit is available; an issue this cycle is accepted
//   i_xPower   : power3.o_xPower
//   o_data     : result at the FIFO head (zero when o_valid is low)
//   o_valid    : FIFO non-empty
//   i_ready    : consumer takes o_data this cycle
//   o_overflow : sticky flag, set by an issue made without a credit
module power3_result_buffer #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 8
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_xValid,
  output logic       o_xReady,
  input  logic [7:0] i_xPower,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 8;

  // State registers
  logic [PW-1:0]      credits_q, credits_d;
  logic               ready_q, ready_d;
  logic [LATENCY-1:0] pipe_q, pipe_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      data_q, data_d;
  logic               ovf_q, ovf_d;
  logic               armed_q;

  logic [DW-1:0]      mem [DEPTH];

  // Per-cycle events
  logic               accept;
  logic               reject;
  logic               pop;
  logic               wr_en;
  logic               full;
  logic [DW-1:0]      head;

  // Next-state logic for credits, valid pipe, pointers and registered outputs
  always_comb begin
    accept    = i_xValid && ready_q;
    reject    = i_xValid && !ready_q;
    pop       = valid_q && i_ready;
    wr_en     = pipe_q[LATENCY-1];
    full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    credits_d = credits_q;
    unique case ({accept, pop})
      2'b10:   credits_d = credits_q - PW'(1);
      2'b01:   credits_d = credits_q + PW'(1);
      default: credits_d = credits_q;
    endcase
    // Ready is registered, so i_ready has no combinational path to o_xReady.
    ready_d   = (credits_d != '0);

    // Bit 0 takes the accepted issue; the MSB marks a real result on i_xPower.
    pipe_d    = LATENCY'(pipe_q << 1) | LATENCY'(accept);

    wptr_d    = wptr_q + PW'(wr_en);
    rptr_d    = rptr_q + PW'(pop);
    valid_d   = (wptr_d != rptr_d);

    // A write into the slot that becomes the head must bypass the memory.
    if (wr_en && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
      head = i_xPower;
    end else begin
      head = mem[rptr_d[AW-1:0]];
    end
    data_d    = valid_d ? head : '0;

    ovf_d     = ovf_q | reject;
  end

  // Control and output registers
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      credits_q <= PW'(DEPTH);
      ready_q   <= 1'b1;
      pipe_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      credits_q <= credits_d;
      ready_q   <= ready_d;
      pipe_q    <= pipe_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  // Result storage; contents need no reset because the pointers gate them
  always_ff @(posedge i_clk) begin
    if (!i_srst && wr_en) begin
      mem[wptr_q[AW-1:0]] <= i_xPower;
    end
  end

  assign o_xReady   = ready_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_overflow = ovf_q;

  // Credit conservation: credits + in-flight slots + occupancy == DEPTH
  logic [PW-1:0] occ;
  int unsigned   inflight;

  always_comb begin
    occ      = wptr_q - rptr_q;
    inflight = 0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + 32'(pipe_q[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst && armed_q) begin
      assert (!(wr_en && full));
      assert ((32'(credits_q) + inflight + 32'(occ)) == DEPTH);
    end
  end

endmodule

// File: tb/tb_power3_result_buffer.sv
// Bench for power3_result_buffer: models power3 as a LAT-deep delay of
// accepted issues, drives table vectors and hand-written sequences, and
// compares every cycle against a queue-based reference.
module tb_power3_result_buffer;

  localparam int unsigned LAT = 3;
  localparam int unsigned DEP = 8;

  logic       clk = 1'b0;
  logic       i_srst;
  logic       i_xValid;
  logic       o_xReady;
  logic [7:0] i_xPower;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_overflow;

  always #5 clk = ~clk;

  power3_result_buffer dut (
    .i_clk      (clk),
    .i_srst     (i_srst),
    .i_xValid   (i_xValid),
    .o_xReady   (o_xReady),
    .i_xPower   (i_xPower),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model of the buffer
  int           m_credits = DEP;
  logic [LAT-1:0] m_pipe  = '0;
  logic [7:0]   m_q[$];
  logic         m_ovf     = 1'b0;

  // power3 stand-in: not cleared by reset, so stale results keep emerging
  logic [LAT-1:0] p3_v = '0;
  logic [7:0]     p3_d [LAT];
  int             k_iss = 0;

  typedef struct {
    logic       xv;
    logic       rd;
    logic       ev;
    logic [7:0] ed;
    logic       er;
  } vec_t;
  vec_t vt [12];

  logic [7:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance.
  task automatic tick(input logic xv, input logic rd);
    logic acc;
    logic pop;
    logic [7:0] exp_d;
    i_xValid = xv;
    i_ready  = rd;
    i_xPower = p3_v[LAT-1] ? p3_d[LAT-1] : 8'hEE;
    if (chk_en) begin
      exp_d = (m_q.size() != 0) ? m_q[0] : 8'h00;
      chk("mdl_valid", 32'(o_valid), 32'(m_q.size() != 0));
      chk("mdl_data", 32'(o_data), 32'(exp_d));
      chk("mdl_xready", 32'(o_xReady), 32'(m_credits != 0));
      chk("mdl_overflow", 32'(o_overflow), 32'(m_ovf));
    end
    acc = !i_srst && xv && (m_credits != 0);
    pop = !i_srst && rd && (m_q.size() != 0);
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) p3_d[i] = p3_d[i-1];
    p3_d[0] = 8'(32'h10 + k_iss);
    p3_v    = {p3_v[LAT-2:0], acc};
    if (acc) k_iss++;
    if (i_srst) begin
      m_credits = DEP;
      m_pipe    = '0;
      m_q.delete();
      m_ovf     = 1'b0;
      k_iss     = 0;
    end else begin
      if (xv && (m_credits == 0)) m_ovf = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (m_pipe[LAT-1]) m_q.push_back(i_xPower);
      m_credits = m_credits + int'(pop) - int'(acc);
      m_pipe    = {m_pipe[LAT-2:0], acc};
    end
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_srst = 1'b1;
    tick(1'b1, 1'b0);
    i_srst = 1'b0;
    cyc    = 0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_xready", 32'(o_xReady), 32'd1);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
  endtask

  // Collect a result if one is taken this cycle, then advance.
  task automatic drain_tick();
    if (o_valid) got.push_back(o_data);
    tick(1'b0, 1'b1);
  endtask

  initial begin
    int first;
    int last;
    int gaps;
    int ready_lows;

    for (int i = 0; i < LAT; i++) p3_d[i] = 8'h00;
    i_srst   = 1'b1;
    i_xValid = 1'b0;
    i_ready  = 1'b0;
    i_xPower = 8'hEE;
    tick(1'b0, 1'b0);
    chk_en = 1'b1;

    // Single sample: issue at cycle 5, result visible in cycle 9 only
    for (int i = 0; i < 12; i++) begin
      vt[i] = '{(i == 5), 1'b1, (i == 9), (i == 9) ? 8'h10 : 8'h00, 1'b1};
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(o_data), 32'(vt[i].ed));
      chk($sformatf("vec%0d_xready", i), 32'(o_xReady), 32'(vt[i].er));
      tick(vt[i].xv, vt[i].rd);
    end

    // Fill with no pops: eight credits, then o_xReady drops
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("fill_xready_hi", 32'(o_xReady), 32'd1);
      tick(1'b1, 1'b0);
    end
    chk("fill_xready_lo", 32'(o_xReady), 32'd0);
    repeat (4) tick(1'b0, 1'b0);
    chk("fill_valid", 32'(o_valid), 32'd1);
    chk("fill_head", 32'(o_data), 32'h10);
    chk("fill_no_ovf", 32'(o_overflow), 32'd0);

    // Overflow: one issue without a credit; flag is sticky
    tick(1'b1, 1'b0);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_hold", 32'(o_overflow), 32'd1);
      chk("ovf_stall_data", 32'(o_data), 32'h10);
      tick(1'b0, 1'b0);
    end
    got.delete();
    repeat (12) drain_tick();
    chk("ovf_drain_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("ovf_drain%0d", i), 32'(got[i]), 32'(8'h10 + 8'(i)));
    end
    chk("ovf_sticky", 32'(o_overflow), 32'd1);
    chk("ovf_xready_back", 32'(o_xReady), 32'd1);

    // Streaming: 40 issues back to back with the consumer always ready
    do_reset();
    got.delete();
    first = -1;
    last = -1;
    gaps = 0;
    ready_lows = 0;
    for (int c = 0; c < 48; c++) begin
      if (c < 40 && !o_xReady) ready_lows++;
      if (o_valid) begin
        got.push_back(o_data);
        if (first < 0) first = c;
        else if (c != last + 1) gaps++;
        last = c;
      end
      tick(c < 40, 1'b1);
    end
    chk("stream_count", 32'(got.size()), 32'd40);
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("stream%0d", i), 32'(got[i]), 32'(8'h10 + 8'(i)));
    end
    chk("stream_first", 32'(first), 32'd4);
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_xready_lows", 32'(ready_lows), 32'd0);

    // Backpressure: head holds for three stalled cycles, then pops race writes
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c >= 4) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", 32'(o_data), 32'h10);
      end
      tick(c < 6, 1'b0);
    end
    chk("popwr_data0", 32'(o_data), 32'h10);
    tick(1'b0, 1'b1);
    chk("popwr_data1", 32'(o_data), 32'h11);
    tick(1'b0, 1'b1);
    chk("popwr_data2", 32'(o_data), 32'h12);
    tick(1'b0, 1'b0);
    got.delete();
    repeat (8) drain_tick();
    chk("popwr_remaining", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) begin
      chk($sformatf("popwr_rem%0d", i), 32'(got[i]), 32'(8'h12 + 8'(i)));
    end

    // Reset mid-flight: two queued, two in flight, all discarded
    do_reset();
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("mid_pre_valid", 32'(o_valid), 32'd1);
    chk("mid_pre_data", 32'(o_data), 32'h10);
    i_srst = 1'b1;
    tick(1'b0, 1'b0);
    i_srst = 1'b0;
    chk("mid_post_valid", 32'(o_valid), 32'd0);
    chk("mid_post_xready", 32'(o_xReady), 32'd1);
    chk("mid_post_data", 32'(o_data), 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk("mid_quiet_valid", 32'(o_valid), 32'd0);
      tick(1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
